// File: rtl/byte_stream_pkg.sv
// byte_stream_pkg: definitions shared by the byte stream buffer and its
// shift register.
//   BYTE_W  : width of one streamed byte
//   state_t : sequencer states IDLE -> START -> STREAM -> DONE
package byte_stream_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/byte_shreg.sv
// byte_shreg: DATA_BYTES x 8 shift register feeding the byte stream.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (register -> 0)
//   clear      : zero the register (highest priority)
//   load       : capture load_data
//   shift      : move one byte toward the head, zeros enter at the tail
//   load_data  : word to capture
//   head       : byte currently at the head of the register
// MSB_FIRST=1 keeps the head in the top byte and shifts left; MSB_FIRST=0
// keeps it in the bottom byte and shifts right.
module byte_shreg
  import byte_stream_pkg::*;
#(
  parameter int DATA_BYTES = 69,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         load,
  input  logic                         shift,
  input  logic [DATA_BYTES*BYTE_W-1:0] load_data,
  output logic [BYTE_W-1:0]            head
);

  localparam int W = DATA_BYTES * BYTE_W;

  logic [W-1:0] sreg_q;
  logic [W-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (clear) begin
      sreg_d = '0;
    end else if (load) begin
      sreg_d = load_data;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sreg_d = sreg_q << BYTE_W;
      end else begin
        sreg_d = sreg_q >> BYTE_W;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  if (MSB_FIRST) begin : g_head_msb
    assign head = sreg_q[W-1 -: BYTE_W];
  end else begin : g_head_lsb
    assign head = sreg_q[BYTE_W-1:0];
  end

endmodule

// File: rtl/byte_stream_buffer.sv
// byte_stream_buffer: captures one word of up to DATA_BYTES bytes plus a
// byte count, then streams the bytes one per handshake.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   load_valid/load_ready: load handshake, load_ready high only in IDLE
//   load_data, load_len  : word and byte count (clamped to DATA_BYTES)
//   abort                : synchronous flush back to IDLE, no done pulse
//   ostart               : one-cycle pulse before the first byte
//   ovalid/oready        : byte handshake; a byte moves when both are high
//   obyte, olast         : current byte, high with the final byte
//   done                 : one-cycle pulse after the final transfer
//   sent_cnt             : bytes transferred since the last load
//                          (present only with BYTE_STREAM_CNT_EN defined)
// Handshake: obyte/olast are stable while ovalid && !oready; oready is a
// don't-care whenever ovalid is low.
module byte_stream_buffer
  import byte_stream_pkg::*;
#(
  parameter int  DATA_BYTES = 69,
  parameter bit  MSB_FIRST  = 1'b1,
  localparam int CNT_W      = $clog2(DATA_BYTES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [DATA_BYTES*BYTE_W-1:0] load_data,
  input  logic [CNT_W-1:0]             load_len,
  input  logic                         abort,
  output logic                         ostart,
  output logic                         ovalid,
  input  logic                         oready,
  output logic [BYTE_W-1:0]            obyte,
  output logic                         olast,
  output logic                         done
`ifdef BYTE_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0]             sent_cnt
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] len_clamped;
  logic             ostart_q, ostart_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q, olast_d;
  logic             done_q, done_d;
  logic             accept;
  logic             xfer;

  assign len_clamped = (load_len > CNT_W'(DATA_BYTES)) ? CNT_W'(DATA_BYTES) : load_len;

  // abort beats both a load and a transfer in the same cycle.
  assign accept = (state_q == ST_IDLE) && load_valid && !abort;
  assign xfer   = ovalid_q && oready && !abort;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (abort) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            rem_d   = len_clamped;
            state_d = (len_clamped == '0) ? ST_DONE : ST_START;
          end
        end
        ST_START: state_d = ST_STREAM;
        ST_STREAM: begin
          // STREAM is only entered with rem >= 1, so this cannot underflow.
          if (xfer) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered: decode them from the next state.
    ostart_d = (state_d == ST_START);
    ovalid_d = (state_d == ST_STREAM);
    olast_d  = (state_d == ST_STREAM) && (rem_d == CNT_W'(1));
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      ostart_q <= 1'b0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      ostart_q <= ostart_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      done_q   <= done_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign ostart     = ostart_q;
  assign ovalid     = ovalid_q;
  assign olast      = olast_q;
  assign done       = done_q;

  byte_shreg #(
    .DATA_BYTES(DATA_BYTES),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clear    (abort),
    .load     (accept),
    .shift    (xfer),
    .load_data(load_data),
    .head     (obyte)
  );

`ifdef BYTE_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holds its final value through DONE and IDLE until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (abort || accept) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sent_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_byte_stream_buffer.sv
// tb_byte_stream_buffer: directed bench for byte_stream_buffer.
// dut     : DATA_BYTES=69, MSB_FIRST=1 (PNG word, backpressure, abort, reset)
// dut_lsb : DATA_BYTES=8,  MSB_FIRST=0 (LSB mode and length clamp)
// Define BYTE_STREAM_CNT_EN to also check sent_cnt.
module tb_byte_stream_buffer;

  localparam int DB  = 69;
  localparam int CW  = $clog2(DB + 1);
  localparam int LDB = 8;
  localparam int LCW = $clog2(LDB + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            load_valid, load_ready, abort, ostart, ovalid, oready, olast, done;
  logic [DB*8-1:0] load_data;
  logic [CW-1:0]   load_len;
  logic [7:0]      obyte;

  logic             l_load_valid, l_load_ready, l_abort, l_ostart, l_ovalid, l_oready, l_olast, l_done;
  logic [LDB*8-1:0] l_load_data;
  logic [LCW-1:0]   l_load_len;
  logic [7:0]       l_obyte;

`ifdef BYTE_STREAM_CNT_EN
  logic [CW-1:0]  sent_cnt;
  logic [LCW-1:0] l_sent_cnt;
`endif

  byte_stream_buffer #(.DATA_BYTES(DB), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .abort(abort),
    .ostart(ostart), .ovalid(ovalid), .oready(oready),
    .obyte(obyte), .olast(olast), .done(done)
`ifdef BYTE_STREAM_CNT_EN
    , .sent_cnt(sent_cnt)
`endif
  );

  byte_stream_buffer #(.DATA_BYTES(LDB), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst),
    .load_valid(l_load_valid), .load_ready(l_load_ready),
    .load_data(l_load_data), .load_len(l_load_len), .abort(l_abort),
    .ostart(l_ostart), .ovalid(l_ovalid), .oready(l_oready),
    .obyte(l_obyte), .olast(l_olast), .done(l_done)
`ifdef BYTE_STREAM_CNT_EN
    , .sent_cnt(l_sent_cnt)
`endif
  );

  // scoreboard
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] png[DB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic load_main(input int len);
    for (int i = 0; i < DB; i++) load_data[(DB-1-i)*8 +: 8] = png[i];
    load_len   = CW'(len);
    load_valid = 1'b1;
    oready     = 1'b1;
    check("idle_load_ready", load_ready, 1);
    step();
    load_valid = 1'b0;
    for (int i = 0; i < len && i < DB; i++) exp_q.push_back(png[i]);
  endtask

  // Called in the first cycle with ovalid high. pat 0: oready always 1;
  // pat 1: oready cycles 1,0,0,1. busy_load pulses load_valid mid-stream.
  task automatic run_stream(input int pat, input int n_exp, input bit busy_load);
    int         n = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    while (n < n_exp && cyc < 1000) begin
      oready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (busy_load) begin
        load_valid = (cyc < 3);
        if (cyc == 1) check("busy_load_ready", load_ready, 0);
      end
      if (ovalid) begin
        if (stalled) check($sformatf("hold_byte%0d", n), obyte, held);
        if (oready) begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", n), obyte, e);
          check($sformatf("olast%0d", n), olast, (n == n_exp - 1));
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = obyte;
        end
      end
      step();
      cyc++;
    end
    oready     = 1'b1;
    load_valid = 1'b0;
    check("xfer_count", n, n_exp);
    check("done_pulse", done, 1);
    check("ovalid_after_last", ovalid, 0);
    step();
    check("done_one_cycle", done, 0);
    check("back_to_idle", load_ready, 1);
  endtask

  task automatic lsb_run(input logic [63:0] d, input int len, input int n_exp);
    l_load_data  = d;
    l_load_len   = LCW'(len);
    l_load_valid = 1'b1;
    l_oready     = 1'b1;
    step();
    l_load_valid = 1'b0;
    check("lsb_ostart", l_ostart, 1);
    step();
    for (int i = 0; i < n_exp; i++) begin
      check($sformatf("lsb_byte%0d", i), l_obyte, d[8*i +: 8]);
      check($sformatf("lsb_olast%0d", i), l_olast, (i == n_exp - 1));
      step();
    end
    check("lsb_done", l_done, 1);
    check("lsb_ovalid_after", l_ovalid, 0);
    step();
    check("lsb_idle", l_load_ready, 1);
  endtask

  initial begin
    png = '{8'h89, 8'h50, 8'h4E, 8'h47, 8'h0D, 8'h0A, 8'h1A, 8'h0A,
            8'h00, 8'h00, 8'h00, 8'h0D, 8'h49, 8'h48, 8'h44, 8'h52,
            8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h08, 8'h06, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h15, 8'hC4,
            8'h89, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h49, 8'h44, 8'h41,
            8'h54, 8'h08, 8'hD7, 8'h63, 8'hF8, 8'hFF, 8'hFF, 8'h3F,
            8'h00, 8'h05, 8'hFE, 8'h02, 8'hFE, 8'hDC, 8'hCC, 8'h59,
            8'hE7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h49, 8'h45, 8'h4E,
            8'h44, 8'hAE, 8'h42, 8'h60, 8'h82};
    rst = 1'b1;
    load_valid = 1'b0; load_data = '0; load_len = '0; abort = 1'b0; oready = 1'b0;
    l_load_valid = 1'b0; l_load_data = '0; l_load_len = '0; l_abort = 1'b0; l_oready = 1'b0;

    // reset values
    #12;
    check("rst_load_ready", load_ready, 1);
    check("rst_ostart", ostart, 0);
    check("rst_ovalid", ovalid, 0);
    check("rst_olast", olast, 0);
    check("rst_done", done, 0);
    check("rst_obyte", obyte, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();

    // full PNG word, no stalls
    load_main(69);
    check("png_ostart", ostart, 1);
    check("png_start_ovalid", ovalid, 0);
    check("png_busy_ready", load_ready, 0);
    step();
    check("png_first_valid", ovalid, 1);
    check("png_ostart_once", ostart, 0);
    run_stream(0, 69, 1'b0);
`ifdef BYTE_STREAM_CNT_EN
    check("png_sent_cnt", sent_cnt, 69);
`endif

    // backpressure 1,0,0,1
    load_main(69);
    check("bp_ostart", ostart, 1);
    step();
    run_stream(1, 69, 1'b0);

    // short length with a load attempted while busy
    load_main(4);
    check("short_ostart", ostart, 1);
    step();
    load_data = '1;
    load_len  = CW'(2);
    run_stream(0, 4, 1'b1);

    // zero length: straight to DONE
    load_len   = '0;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("len0_ostart", ostart, 0);
    check("len0_ovalid", ovalid, 0);
    check("len0_done", done, 1);
    step();
    check("len0_done_once", done, 0);
    check("len0_idle", load_ready, 1);
`ifdef BYTE_STREAM_CNT_EN
    check("len0_sent_cnt", sent_cnt, 0);
`endif

    // abort after byte 10, together with a transfer
    load_main(69);
    step();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("abort_byte%0d", i), obyte, exp_q.pop_front());
      step();
    end
    exp_q.delete();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_ovalid", ovalid, 0);
    check("abort_idle", load_ready, 1);
    check("abort_no_done", done, 0);
    check("abort_obyte_clr", obyte, 8'h00);
    check("abort_olast", olast, 0);
`ifdef BYTE_STREAM_CNT_EN
    check("abort_sent_cnt", sent_cnt, 0);
`endif
    step();
    check("abort_no_done_later", done, 0);
    load_main(4);
    check("reload_ostart", ostart, 1);
    step();
    run_stream(0, 4, 1'b0);

    // asynchronous reset mid-stream
    load_main(69);
    exp_q.delete();
    step();
    step();
    step();
    check("pre_rst_ovalid", ovalid, 1);
    rst = 1'b1;
    #1;
    check("arst_ovalid", ovalid, 0);
    check("arst_obyte", obyte, 8'h00);
    check("arst_olast", olast, 0);
    check("arst_ostart", ostart, 0);
    check("arst_done", done, 0);
    check("arst_load_ready", load_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("arst_no_done", done, 0);
    check("arst_stay_idle", ovalid, 0);

    // LSB-first mode and length clamp
    lsb_run(64'hAABBCCDD_44332211, 3, 3);
`ifdef BYTE_STREAM_CNT_EN
    check("lsb_sent_cnt3", l_sent_cnt, 3);
`endif
    lsb_run(64'h88776655_44332211, 15, 8);
`ifdef BYTE_STREAM_CNT_EN
    check("lsb_sent_cnt8", l_sent_cnt, 8);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
